// File: rtl/exponent_accelerator_system_hex_bank.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with per-digit
// hex/raw mode, blank and blink masks; out_port is registered, readdata is combinational.
module exponent_accelerator_system_hex_bank #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned NIB_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DECODE = 3'd1;
    localparam logic [2:0] ADDR_RAW_LO = 3'd2;
    localparam logic [2:0] ADDR_RAW_HI = 3'd3;
    localparam logic [2:0] ADDR_BLANK  = 3'd4;
    localparam logic [2:0] ADDR_BLINK  = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    // Pattern for a lit "0", after the board polarity is applied.
    localparam logic [6:0]       ZERO_SEG = (ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;
    localparam logic [SEG_W-1:0] RST_OUT  = {NUM_DIGITS{ZERO_SEG}};

    logic [NIB_W-1:0]      data_q;
    logic [NUM_DIGITS-1:0] decode_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] blink_q;
    logic [6:0]            raw_q [NUM_DIGITS];
    logic [CNT_W-1:0]      cnt_q;
    logic                  phase_q;

    logic                  wr_en;
    logic                  restart;
    logic [SEG_W-1:0]      out_d;
    logic [6:0]            seg;
    logic                  unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign restart      = wr_en && (address == ADDR_STATUS) && writedata[0];
    assign unused_wdata = ^writedata;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_seg = 7'h3F;
            4'h1:    hex_seg = 7'h06;
            4'h2:    hex_seg = 7'h5B;
            4'h3:    hex_seg = 7'h4F;
            4'h4:    hex_seg = 7'h66;
            4'h5:    hex_seg = 7'h6D;
            4'h6:    hex_seg = 7'h7D;
            4'h7:    hex_seg = 7'h07;
            4'h8:    hex_seg = 7'h7F;
            4'h9:    hex_seg = 7'h6F;
            4'hA:    hex_seg = 7'h77;
            4'hB:    hex_seg = 7'h7C;
            4'hC:    hex_seg = 7'h39;
            4'hD:    hex_seg = 7'h5E;
            4'hE:    hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    // Register file; writes to fields of absent digits fall outside the stored width.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            decode_q <= '1;
            blank_q  <= '0;
            blink_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_q   <= writedata[NIB_W-1:0];
                ADDR_DECODE: decode_q <= writedata[NUM_DIGITS-1:0];
                ADDR_BLANK:  blank_q  <= writedata[NUM_DIGITS-1:0];
                ADDR_BLINK:  blink_q  <= writedata[NUM_DIGITS-1:0];
                ADDR_RAW_LO, ADDR_RAW_HI: begin
                    // Digits 0..3 live in RAW_LO, 4..7 in RAW_HI, one byte lane each.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if ((i < 4) == (address == ADDR_RAW_LO)) begin
                            raw_q[i] <= writedata[8*(i%4) +: 7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running blink timebase; a restart beats a coincident wrap.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Per-digit pattern: blank, then blink-dark, then decoded/raw; polarity last.
    always_comb begin
        out_d = '0;
        seg   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg = decode_q[i] ? hex_seg(data_q[4*i +: 4]) : raw_q[i];
            if (blank_q[i] || (blink_q[i] && phase_q)) begin
                seg = '0;
            end
            if (ACTIVE_LOW != 0) begin
                seg = ~seg;
            end
            out_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= RST_OUT;
        end else begin
            out_port <= out_d;
        end
    end

    // Read mux is independent of chipselect; the interconnect qualifies it.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[NIB_W-1:0]      = data_q;
            ADDR_DECODE: readdata[NUM_DIGITS-1:0] = decode_q;
            ADDR_BLANK:  readdata[NUM_DIGITS-1:0] = blank_q;
            ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_q;
            ADDR_RAW_LO, ADDR_RAW_HI: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if ((i < 4) == (address == ADDR_RAW_LO)) begin
                        readdata[8*(i%4) +: 7] = raw_q[i];
                    end
                end
            end
            ADDR_STATUS: readdata[0] = phase_q;
            default: ;
        endcase
    end

endmodule
